// File: rtl/wts_channel_scheduler_if.sv
// Bus between the CPU request side, the slot scheduler and the envelope engine.
// Requests are single-cycle pulses with no backpressure; engine outputs are combinational each cycle.
interface wts_channel_scheduler_if #(
  parameter int NUM_CH = 5
);
  logic              enable;
  logic [NUM_CH-1:0] key_on_req;
  logic [NUM_CH-1:0] key_release_req;
  logic [NUM_CH-1:0] key_off_req;
  logic [2:0]        active;
  logic [NUM_CH-1:0] key_on;
  logic [NUM_CH-1:0] key_release;
  logic [NUM_CH-1:0] key_off;
  logic              frame_start;
  logic [NUM_CH-1:0] pending;

  modport master (
    output enable, key_on_req, key_release_req, key_off_req,
    input  active, key_on, key_release, key_off, frame_start, pending
  );

  modport slave (
    input  enable, key_on_req, key_release_req, key_off_req,
    output active, key_on, key_release, key_off, frame_start, pending
  );
endinterface

// File: rtl/wts_channel_scheduler.sv
// Slot sequencer for the time-multiplexed ADSR engine: walks NUM_CH channel slots plus
// one idle slot and releases each channel's latched key request in its service cycle.
module wts_channel_scheduler #(
  parameter int NUM_CH      = 5,
  parameter int SLOT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  wts_channel_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    CODE_NONE = 2'd0,
    CODE_ON   = 2'd1,
    CODE_REL  = 2'd2,
    CODE_OFF  = 2'd3
  } code_e;

  localparam logic [2:0] IDLE_SLOT = 3'(NUM_CH);
  localparam logic [7:0] LAST_P    = 8'(SLOT_CYCLES - 1);

  logic [2:0]        s_q, s_d;
  logic [7:0]        p_q, p_d;
  code_e             code_q [NUM_CH];
  code_e             code_d [NUM_CH];
  logic              service;
  logic [NUM_CH-1:0] key_on_o, key_release_o, key_off_o, pending_o;

  // Reset gates service so the engine sees the idle slot for the whole reset pulse.
  assign service = !reset && bus.enable && (p_q == 8'd0) && (s_q < IDLE_SLOT);

  always_comb begin
    s_d = s_q;
    p_d = p_q;
    if (bus.enable) begin
      if (p_q == LAST_P) begin
        p_d = 8'd0;
        s_d = (s_q == IDLE_SLOT) ? 3'd0 : s_q + 3'd1;
      end else begin
        p_d = p_q + 8'd1;
      end
    end
  end

  always_comb begin
    key_on_o      = '0;
    key_release_o = '0;
    key_off_o     = '0;
    pending_o     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      code_d[c]    = code_q[c];
      pending_o[c] = (code_q[c] != CODE_NONE);
      // A request landing in the service cycle replaces the code after it is emitted.
      if (bus.key_off_req[c])          code_d[c] = CODE_OFF;
      else if (bus.key_on_req[c])      code_d[c] = CODE_ON;
      else if (bus.key_release_req[c]) code_d[c] = CODE_REL;
      else if (service && s_q == 3'(c)) code_d[c] = CODE_NONE;
      if (service && s_q == 3'(c)) begin
        case (code_q[c])
          CODE_ON:  key_on_o[c]      = 1'b1;
          CODE_REL: key_release_o[c] = 1'b1;
          CODE_OFF: key_off_o[c]     = 1'b1;
          default:  ;
        endcase
      end
    end
  end

  assign bus.active      = service ? s_q : IDLE_SLOT;
  assign bus.frame_start = service && (s_q == 3'd0);
  assign bus.key_on      = key_on_o;
  assign bus.key_release = key_release_o;
  assign bus.key_off     = key_off_o;
  assign bus.pending     = pending_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= 3'd0;
      p_q <= 8'd0;
      for (int c = 0; c < NUM_CH; c++) code_q[c] <= CODE_NONE;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
      for (int c = 0; c < NUM_CH; c++) code_q[c] <= code_d[c];
    end
  end

endmodule

// File: tb/tb_wts_channel_scheduler.sv
// Directed bench for wts_channel_scheduler: one instance with single-cycle slots and
// one with four-cycle slots, checked against hand-computed slot sequences and key pulses.
module tb_wts_channel_scheduler;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wts_channel_scheduler_if #(.NUM_CH(5)) if0 ();
  wts_channel_scheduler_if #(.NUM_CH(5)) if4 ();

  wts_channel_scheduler #(.NUM_CH(5), .SLOT_CYCLES(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  wts_channel_scheduler #(.NUM_CH(5), .SLOT_CYCLES(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] on, input logic [4:0] rel, input logic [4:0] off);
    if0.key_on_req      = on;
    if0.key_release_req = rel;
    if0.key_off_req     = off;
    step();
    if0.key_on_req      = '0;
    if0.key_release_req = '0;
    if0.key_off_req     = '0;
  endtask

  task automatic wait_active(input logic [2:0] ch);
    int n;
    n = 0;
    while (if0.active !== ch && n < 20) begin
      step();
      n++;
    end
    check("wait_active", {29'd0, if0.active}, {29'd0, ch});
  endtask

  task automatic check_keys(input string tag, input logic [4:0] on, input logic [4:0] rel,
                            input logic [4:0] off);
    check({tag, "_on"},  {27'd0, if0.key_on},      {27'd0, on});
    check({tag, "_rel"}, {27'd0, if0.key_release}, {27'd0, rel});
    check({tag, "_off"}, {27'd0, if0.key_off},     {27'd0, off});
  endtask

  initial begin
    int p;
    logic [2:0] e4;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    if0.enable = 1'b1;
    if0.key_on_req = '0;
    if0.key_release_req = '0;
    if0.key_off_req = '0;
    if4.enable = 1'b1;
    if4.key_on_req = '0;
    if4.key_release_req = '0;
    if4.key_off_req = '0;

    // reset state
    repeat (2) step();
    check("rst_active", {29'd0, if0.active}, 32'd5);
    check("rst_active4", {29'd0, if4.active}, 32'd5);
    check("rst_pending", {27'd0, if0.pending}, 32'd0);
    check("rst_frame", {31'd0, if0.frame_start}, 32'd0);
    check_keys("rst", 5'd0, 5'd0, 5'd0);

    // free-running frames on both instances
    reset = 1'b0;
    #1;
    for (int i = 0; i < 30; i++) begin
      p  = i % 24;
      e4 = (p % 4 == 0 && p < 20) ? 3'(p / 4) : 3'd5;
      check("seq_active", {29'd0, if0.active}, 32'(i % 6));
      check("seq_frame", {31'd0, if0.frame_start}, {31'd0, (i % 6) == 0});
      check("seq4_active", {29'd0, if4.active}, {29'd0, e4});
      check("seq4_frame", {31'd0, if4.frame_start}, {31'd0, p == 0});
      check("seq_keys", {27'd0, if0.key_on | if0.key_release | if0.key_off}, 32'd0);
      step();
    end

    // key-on to channel 2 issued during slot 0
    wait_active(3'd0);
    pulse(5'b00100, 5'd0, 5'd0);
    check("on2_active", {29'd0, if0.active}, 32'd1);
    check("on2_pend", {27'd0, if0.pending}, 32'b00100);
    check_keys("on2_early", 5'd0, 5'd0, 5'd0);
    step();
    check("on2_svc_active", {29'd0, if0.active}, 32'd2);
    check_keys("on2_svc", 5'b00100, 5'd0, 5'd0);
    step();
    check("on2_pend_clr", {27'd0, if0.pending}, 32'd0);
    check_keys("on2_after", 5'd0, 5'd0, 5'd0);
    repeat (5) step();
    check("on2_next_active", {29'd0, if0.active}, 32'd2);
    check_keys("on2_next", 5'd0, 5'd0, 5'd0);

    // later request overwrites; same-cycle priority
    wait_active(3'd2);
    pulse(5'b00010, 5'd0, 5'd0);
    pulse(5'd0, 5'd0, 5'b00010);
    wait_active(3'd1);
    check_keys("ovr1", 5'd0, 5'd0, 5'b00010);
    wait_active(3'd0);
    pulse(5'b10000, 5'b10000, 5'd0);
    wait_active(3'd4);
    check_keys("prio4", 5'b10000, 5'd0, 5'd0);

    // request arriving in the channel's own service cycle
    wait_active(3'd0);
    pulse(5'd0, 5'b01000, 5'd0);
    wait_active(3'd3);
    if0.key_on_req = 5'b01000;
    #1;
    check_keys("svc3_old", 5'd0, 5'b01000, 5'd0);
    step();
    if0.key_on_req = '0;
    check("svc3_pend", {27'd0, if0.pending}, 32'b01000);
    repeat (2) step();
    check("svc3_pend_mid", {27'd0, if0.pending}, 32'b01000);
    repeat (3) step();
    check("svc3_active", {29'd0, if0.active}, 32'd3);
    check_keys("svc3_new", 5'b01000, 5'd0, 5'd0);
    step();
    check("svc3_pend_clr", {27'd0, if0.pending}, 32'd0);

    // enable dropped with slot 2 pending service
    wait_active(3'd1);
    step();
    if0.enable = 1'b0;
    #1;
    check("en_active_drop", {29'd0, if0.active}, 32'd5);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) pulse(5'd0, 5'd0, 5'b00001);
      else step();
      check("en_active_hold", {29'd0, if0.active}, 32'd5);
      check("en_keys", {27'd0, if0.key_on | if0.key_release | if0.key_off}, 32'd0);
    end
    check("en_pend", {27'd0, if0.pending}, 32'b00001);
    if0.enable = 1'b1;
    #1;
    check("en_resume", {29'd0, if0.active}, 32'd2);
    repeat (4) step();
    check("en_slot0", {29'd0, if0.active}, 32'd0);
    check_keys("en_off0", 5'd0, 5'd0, 5'b00001);

    // asynchronous reset mid-frame discards pending work
    wait_active(3'd1);
    pulse(5'b01000, 5'd0, 5'd0);
    check("mr_pend", {27'd0, if0.pending}, 32'b01000);
    reset = 1'b1;
    #1;
    check("mr_active", {29'd0, if0.active}, 32'd5);
    check("mr_pend_clr", {27'd0, if0.pending}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("mr_restart", {29'd0, if0.active}, 32'd0);
    check("mr_frame", {31'd0, if0.frame_start}, 32'd1);
    repeat (3) step();
    check("mr_active3", {29'd0, if0.active}, 32'd3);
    check_keys("mr_keys3", 5'd0, 5'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
